arbiter_rr_n: RTL and testbench
===============================

Name: arbiter_rr_n

Overview:
- Parametrised N-requester arbiter; next generation of the two-port req/gnt arbiter.
- Registered one-hot grant with selectable round-robin or fixed-priority mode.
- Grant is held while the owner keeps requesting, bounded by a hold timeout when others are waiting.
- Sits between bus masters and a single shared resource.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
MAX_HOLD, 16, max consecutive grant cycles while another requester waits; 0 disables the timeout
ID_W, $clog2(NUM_REQ), width of gnt_id (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req  input  NUM_REQ  request vector; req[i] from requester i
prio_mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins); sampled only at arbitration points
gnt  output  NUM_REQ  one-hot grant (all zero when idle), registered
gnt_valid  output  1  OR of gnt, registered
gnt_id  output  ID_W  index of the granted requester; 0 when idle
timeout  output  1  one-cycle pulse on the cycle a grant is revoked by MAX_HOLD

Behaviour:
- Single clock domain. Reset is synchronous and active-high. Reset takes priority over all other inputs.
- Reset values: gnt=0, gnt_valid=0, gnt_id=0, timeout=0, state IDLE, hold_cnt=0, rr_ptr=NUM_REQ-1, so req[0] has top round-robin priority after reset.
- States:
  - IDLE: no owner.
  - GRANT: owner = gnt_id.
- IDLE: if req != 0, pick a winner from req → GRANT. gnt is asserted on the next edge (1-cycle latency), hold_cnt=1. Otherwise stay in IDLE.
- GRANT, arbitration point (release) when either:
  - (a) req[owner]==0, with candidates = req; or
  - (b) MAX_HOLD!=0, hold_cnt==MAX_HOLD and (req & ~onehot(owner))!=0, with candidates = req & ~onehot(owner). timeout=1 for that cycle.
- At a release:
  - If candidates != 0: grant moves directly to the winner on the next edge (no idle bubble), hold_cnt=1.
  - Otherwise → IDLE and gnt=0 next cycle.
- GRANT, no release: grant holds and hold_cnt increments. hold_cnt saturates at MAX_HOLD; it does not wrap.
  - Consequence: an owner with no competitors holds the grant indefinitely.
  - A competitor arriving after saturation forces revocation on the next edge.
- Winner selection:
  - Fixed priority: lowest set index.
  - Round-robin: first set index scanning rr_ptr+1, rr_ptr+2 … modulo NUM_REQ. rr_ptr updates to the winner at each new grant.
- A requester that drops req gets its grant removed on the next edge. Grant is never given to a requester whose req was 0 at the deciding edge.
- prio_mode changes mid-grant have no effect until the next arbitration point.
- Invariants: gnt is zero or one-hot at all times; gnt_valid==|gnt; gnt_id matches gnt.
- Reset asserted mid-grant: all outputs return to reset values on that edge and any pending timeout is cancelled.

Decomposition:
- Package arbiter_pkg holds:
  - state enum (ST_IDLE, ST_GRANT);
  - constants PRIO_RR=0, PRIO_FIXED=1;
  - function onehot_to_idx.
- One combinational sub-module, arbiter_rr_pick (NUM_REQ param; inputs candidates, rr_ptr, prio_mode; outputs winner one-hot and index), implements both selection modes.
- FSM, hold counter and output registers live in the top.

Test Plan:
- Reset, then req=4'b0101 in RR mode → gnt=0001 one cycle later; drop req[0] → gnt=0100 next cycle with no idle gap.
- RR fairness: req=4'b1111 held constant, MAX_HOLD=0, each owner drops and re-raises its req for one cycle after 2 cycles of grant → grant order 0,1,2,3,0.
- Timeout: MAX_HOLD=4, req=0011 held constant → gnt=0001 for exactly 4 cycles, timeout pulse on the 4th, then gnt=0010 for 4, alternating.
- Lone owner: MAX_HOLD=4, req=0001 for 20 cycles → gnt=0001 throughout, timeout never pulses; raise req[2] at cycle 20 → gnt=0100 next edge, timeout=1 on cycle 20.
- Fixed priority: prio_mode=1, req=1110 → gnt=0010; req[1] drops with req=1100 → gnt=0100; prio_mode toggled mid-grant → no change until release.
- Reset mid-grant: gnt=1000 active, hold_cnt=3, reset for 1 cycle with req=1000 → all outputs 0 at that edge, gnt=1000 one cycle after reset deasserts, hold_cnt restarts at 1.

Source files
------------

// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the N-requester round-robin / fixed-priority arbiter.
package arbiter_pkg;

  // Arbiter FSM: no owner, or one requester currently owns the resource.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Values of the prio_mode input.
  localparam logic PRIO_RR    = 1'b0;
  localparam logic PRIO_FIXED = 1'b1;

  // Index of the set bit in a one-hot vector of up to 16 bits (0 when empty).
  function automatic logic [3:0] onehot_to_idx(input logic [15:0] onehot);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (onehot[i]) begin
        idx = idx | 4'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/arbiter_rr_pick.sv
// Combinational winner selection: lowest set index (fixed priority) or the first
// set index after rr_ptr, wrapping modulo NUM_REQ (round-robin).
module arbiter_rr_pick
  import arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] candidates,
  input  logic [ID_W-1:0]    rr_ptr,
  input  logic               prio_mode,
  output logic [NUM_REQ-1:0] winner,
  output logic [ID_W-1:0]    winner_idx
);

  logic [ID_W-1:0] sel;
  logic            hit;
  int              scan_pos;
  logic [15:0]     winner_wide;
  logic [3:0]      idx_wide;

  // Scan in reverse priority order so the highest-priority candidate is written last.
  always_comb begin
    sel      = '0;
    hit      = 1'b0;
    scan_pos = 0;
    if (prio_mode == PRIO_FIXED) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (candidates[i]) begin
          sel = ID_W'(i);
          hit = 1'b1;
        end
      end
    end else begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        scan_pos = (int'(rr_ptr) + k) % NUM_REQ;
        if (candidates[scan_pos[ID_W-1:0]]) begin
          sel = scan_pos[ID_W-1:0];
          hit = 1'b1;
        end
      end
    end
  end

  // Decode the selected index into the one-hot winner vector.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_winner
    assign winner[gi] = hit && (sel == ID_W'(gi));
  end

  // Widen the winner so the shared 16-bit helper can encode it.
  always_comb begin
    winner_wide                = '0;
    winner_wide[NUM_REQ-1:0]   = winner;
  end

  assign idx_wide   = onehot_to_idx(winner_wide);
  assign winner_idx = idx_wide[ID_W-1:0];

endmodule

// File: rtl/arbiter_rr_n.sv
// N-requester arbiter with registered one-hot grant, round-robin or fixed priority,
// grant holding while the owner requests, and a MAX_HOLD revocation when others wait.
module arbiter_rr_n
  import arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 16,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               prio_mode,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id,
  output logic               timeout
);

  // With MAX_HOLD=0 the counter is never compared, so a 1-bit saturating counter suffices.
  localparam int HOLD_W   = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int HOLD_SAT = (MAX_HOLD < 1) ? 1 : MAX_HOLD;
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_SAT);

  state_t              state_reg, state_next;
  logic [NUM_REQ-1:0]  gnt_reg, gnt_next;
  logic                gnt_valid_reg, gnt_valid_next;
  logic [ID_W-1:0]     gnt_id_reg, gnt_id_next;
  logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
  logic [ID_W-1:0]     rr_ptr_reg, rr_ptr_next;

  logic                owner_req;
  logic [NUM_REQ-1:0]  others;
  logic                rel_drop;
  logic                rel_timeout;
  logic [NUM_REQ-1:0]  candidates;
  logic [NUM_REQ-1:0]  win;
  logic [ID_W-1:0]     win_idx;

  assign owner_req   = |(req & gnt_reg);
  assign others      = req & ~gnt_reg;
  assign rel_drop    = (state_reg == ST_GRANT) && !owner_req;
  assign rel_timeout = (MAX_HOLD != 0) && (state_reg == ST_GRANT) && owner_req &&
                       (hold_cnt_reg == HOLD_LIM) && (|others);

  // Candidate set at an arbitration point; the owner is excluded on a forced revocation.
  always_comb begin
    candidates = '0;
    if (state_reg == ST_IDLE || rel_drop) begin
      candidates = req;
    end else if (rel_timeout) begin
      candidates = others;
    end
  end

  arbiter_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .candidates(candidates),
    .rr_ptr    (rr_ptr_reg),
    .prio_mode (prio_mode),
    .winner    (win),
    .winner_idx(win_idx)
  );

  // Next-state and next-output logic: re-arbitrate at release points, otherwise hold.
  always_comb begin
    state_next     = state_reg;
    gnt_next       = gnt_reg;
    gnt_valid_next = gnt_valid_reg;
    gnt_id_next    = gnt_id_reg;
    hold_cnt_next  = hold_cnt_reg;
    rr_ptr_next    = rr_ptr_reg;
    if (state_reg == ST_IDLE || rel_drop || rel_timeout) begin
      if (|win) begin
        state_next     = ST_GRANT;
        gnt_next       = win;
        gnt_valid_next = 1'b1;
        gnt_id_next    = win_idx;
        hold_cnt_next  = HOLD_W'(1);
        rr_ptr_next    = win_idx;
      end else begin
        state_next     = ST_IDLE;
        gnt_next       = '0;
        gnt_valid_next = 1'b0;
        gnt_id_next    = '0;
        hold_cnt_next  = '0;
      end
    end else if (hold_cnt_reg != HOLD_LIM) begin
      hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
    end
  end

  // State and output registers; reset puts req[0] at the head of the round-robin order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      gnt_reg       <= '0;
      gnt_valid_reg <= 1'b0;
      gnt_id_reg    <= '0;
      hold_cnt_reg  <= '0;
      rr_ptr_reg    <= ID_W'(NUM_REQ - 1);
    end else begin
      state_reg     <= state_next;
      gnt_reg       <= gnt_next;
      gnt_valid_reg <= gnt_valid_next;
      gnt_id_reg    <= gnt_id_next;
      hold_cnt_reg  <= hold_cnt_next;
      rr_ptr_reg    <= rr_ptr_next;
    end
  end

  assign gnt       = gnt_reg;
  assign gnt_valid = gnt_valid_reg;
  assign gnt_id    = gnt_id_reg;
  // Revocation pulse is visible during the cycle it takes effect; reset cancels it.
  assign timeout   = rel_timeout && !reset;

endmodule

// File: tb/tb_arbiter_rr_n.sv
// Testbench: two arbiters (MAX_HOLD=0 and MAX_HOLD=4) share stimulus and are compared
// against a behavioural model of the arbitration rules.
module tb_arbiter_rr_n;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       prio_mode;

  logic [3:0] gnt0, gnt4;
  logic       gv0, gv4;
  logic [1:0] id0, id4;
  logic       to0, to4;

  always #5 clk = ~clk;

  arbiter_rr_n #(.NUM_REQ(4), .MAX_HOLD(0)) u_dut0 (
    .clk(clk), .reset(reset), .req(req), .prio_mode(prio_mode),
    .gnt(gnt0), .gnt_valid(gv0), .gnt_id(id0), .timeout(to0)
  );

  arbiter_rr_n #(.NUM_REQ(4), .MAX_HOLD(4)) u_dut4 (
    .clk(clk), .reset(reset), .req(req), .prio_mode(prio_mode),
    .gnt(gnt4), .gnt_valid(gv4), .gnt_id(id4), .timeout(to4)
  );

  int total = 0;
  int bad   = 0;

  // Model state per instance: owner (-1 = none), consecutive grant cycles, RR pointer.
  int   m_owner[2];
  int   m_hold[2];
  int   m_ptr[2];
  int   maxh[2] = '{0, 4};

  logic [7:0] obs[2];
  logic [7:0] exp_v[2];
  logic       obs_to[2];
  logic       exp_to[2];

  function automatic int pick(input logic [3:0] cand, input int ptr, input logic fixed);
    int res;
    int pos;
    res = -1;
    if (fixed) begin
      for (int i = 3; i >= 0; i--) if (cand[i]) res = i;
    end else begin
      for (int k = 4; k >= 1; k--) begin
        pos = (ptr + k) % 4;
        if (cand[pos]) res = pos;
      end
    end
    return res;
  endfunction

  function automatic logic owner_requests(input int d, input logic [3:0] r);
    int own;
    own = m_owner[d];
    if (own < 0) return 1'b0;
    return r[own[1:0]];
  endfunction

  function automatic logic model_timeout(input int d, input logic [3:0] r, input logic rst);
    int own;
    own = m_owner[d];
    if (rst || own < 0 || maxh[d] == 0) return 1'b0;
    return owner_requests(d, r) && (m_hold[d] == maxh[d]) && ((r & ~(4'b1 << own)) != 4'b0);
  endfunction

  task automatic model_update(input int d, input logic [3:0] r, input logic pm, input logic rst);
    logic [3:0] cand;
    int w;
    logic to;
    to = model_timeout(d, r, rst);
    if (rst) begin
      m_owner[d] = -1; m_hold[d] = 0; m_ptr[d] = 3;
    end else if (m_owner[d] < 0 || !owner_requests(d, r) || to) begin
      cand = to ? (r & ~(4'b1 << m_owner[d])) : r;
      w = pick(cand, m_ptr[d], pm);
      if (w >= 0) begin
        m_owner[d] = w; m_hold[d] = 1; m_ptr[d] = w;
      end else begin
        m_owner[d] = -1; m_hold[d] = 0;
      end
    end else if (maxh[d] == 0 || m_hold[d] < maxh[d]) begin
      m_hold[d] = m_hold[d] + 1;
    end
  endtask

  // One clock cycle, entered and left at a falling edge. Captures the pre-edge timeout,
  // advances the model at the rising edge and collects post-edge outputs.
  task automatic tick(input logic [3:0] r, input logic pm, input logic rst);
    req = r; prio_mode = pm; reset = rst;
    #1;
    obs_to[0] = to0;
    obs_to[1] = to4;
    for (int d = 0; d < 2; d++) exp_to[d] = model_timeout(d, r, rst);
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_update(d, r, pm, rst);
    @(negedge clk);
    obs[0] = {obs_to[0], id0, gv0, gnt0};
    obs[1] = {obs_to[1], id4, gv4, gnt4};
    for (int d = 0; d < 2; d++) begin
      if (m_owner[d] >= 0)
        exp_v[d] = {exp_to[d], 2'(m_owner[d]), 1'b1, 4'(4'b1 << m_owner[d])};
      else
        exp_v[d] = {exp_to[d], 2'b00, 1'b0, 4'b0000};
    end
  endtask

  task automatic test_reset();
    tick(4'b0000, 1'b0, 1'b1);
    tick(4'b0110, 1'b0, 1'b1);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs[d] !== 8'h00) begin
        bad++; $display("FAIL reset dut%0d: got %b want %b", d, obs[d], 8'h00);
      end
    end
    $display("reset: dut0=%b dut4=%b", obs[0], obs[1]);
  endtask

  task automatic test_basic();
    tick(4'b0000, 1'b0, 1'b1);
    tick(4'b0101, 1'b0, 1'b0);
    total++;
    if (gnt4 !== 4'b0001) begin
      bad++; $display("FAIL basic_first: got %b want 0001", gnt4);
    end
    $display("basic req=0101 gnt=%b", gnt4);
    tick(4'b0100, 1'b0, 1'b0);
    total++;
    if (gnt4 !== 4'b0100 || gv4 !== 1'b1) begin
      bad++; $display("FAIL basic_handover: got %b/%b want 0100/1", gnt4, gv4);
    end
    $display("basic req=0100 gnt=%b", gnt4);
    tick(4'b0000, 1'b0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs[d] !== exp_v[d]) begin
        bad++; $display("FAIL basic_idle dut%0d: got %b want %b", d, obs[d], exp_v[d]);
      end
    end
  endtask

  task automatic test_rr_fairness();
    logic [3:0] sched[9] = '{4'b1111, 4'b1111, 4'b1110, 4'b1111, 4'b1101,
                             4'b1111, 4'b1011, 4'b1111, 4'b0111};
    int order[5] = '{0, 1, 2, 3, 0};
    tick(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      tick(sched[i], 1'b0, 1'b0);
      for (int d = 0; d < 2; d++) begin
        total++;
        if (obs[d] !== exp_v[d]) begin
          bad++; $display("FAIL rr dut%0d step%0d: got %b want %b", d, i, obs[d], exp_v[d]);
        end
      end
      if (i % 2 == 0) begin
        total++;
        if (id0 !== 2'(order[i/2]) || gv0 !== 1'b1) begin
          bad++; $display("FAIL rr_order step%0d: got id %0d want %0d", i, id0, order[i/2]);
        end
        $display("rr step%0d req=%b gnt_id=%0d", i, sched[i], id0);
      end
    end
  endtask

  task automatic test_timeout();
    logic [3:0] want;
    logic       want_to;
    tick(4'b0000, 1'b0, 1'b1);
    for (int k = 1; k <= 17; k++) begin
      tick(4'b0011, 1'b0, 1'b0);
      want    = (((k - 1) / 4) % 2 == 1) ? 4'b0010 : 4'b0001;
      want_to = (k >= 5) && ((k - 1) % 4 == 0);
      total++;
      if (gnt4 !== want || obs_to[1] !== want_to) begin
        bad++; $display("FAIL timeout k%0d: got gnt=%b to=%b want gnt=%b to=%b",
                        k, gnt4, obs_to[1], want, want_to);
      end
      for (int d = 0; d < 2; d++) begin
        total++;
        if (obs[d] !== exp_v[d]) begin
          bad++; $display("FAIL timeout_model dut%0d k%0d: got %b want %b", d, k, obs[d], exp_v[d]);
        end
      end
      $display("timeout k=%0d gnt=%b pulse=%b", k, gnt4, obs_to[1]);
    end
  endtask

  task automatic test_lone_owner();
    int errs;
    errs = 0;
    tick(4'b0000, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      tick(4'b0001, 1'b0, 1'b0);
      if (gnt4 !== 4'b0001 || obs_to[1] !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL lone_hold: got %0d bad cycles want 0", errs);
    end
    tick(4'b0101, 1'b0, 1'b0);
    total++;
    if (obs_to[1] !== 1'b1 || gnt4 !== 4'b0100) begin
      bad++; $display("FAIL lone_revoke: got to=%b gnt=%b want to=1 gnt=0100", obs_to[1], gnt4);
    end
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs[d] !== exp_v[d]) begin
        bad++; $display("FAIL lone_model dut%0d: got %b want %b", d, obs[d], exp_v[d]);
      end
    end
    $display("lone owner revoke: pulse=%b gnt=%b", obs_to[1], gnt4);
  endtask

  task automatic test_fixed();
    logic [3:0] r_seq[6]  = '{4'b1110, 4'b1110, 4'b1110, 4'b1100, 4'b1011, 4'b1011};
    logic       p_seq[6]  = '{1'b1,    1'b0,    1'b0,    1'b1,    1'b1,    1'b0};
    logic [3:0] g_seq[6]  = '{4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0001, 4'b0001};
    tick(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick(r_seq[i], p_seq[i], 1'b0);
      total++;
      if (gnt4 !== g_seq[i] || gnt0 !== g_seq[i]) begin
        bad++; $display("FAIL fixed step%0d: got %b/%b want %b", i, gnt0, gnt4, g_seq[i]);
      end
      $display("fixed step%0d req=%b mode=%b gnt=%b", i, r_seq[i], p_seq[i], gnt4);
    end
  endtask

  task automatic test_reset_mid_grant();
    tick(4'b0000, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) tick(4'b1000, 1'b0, 1'b0);
    tick(4'b1000, 1'b0, 1'b1);
    total++;
    if (obs[1] !== 8'h00 || obs[0] !== 8'h00) begin
      bad++; $display("FAIL midreset_clear: got %b/%b want 0", obs[0], obs[1]);
    end
    tick(4'b1000, 1'b0, 1'b0);
    total++;
    if (gnt4 !== 4'b1000) begin
      bad++; $display("FAIL midreset_regrant: got %b want 1000", gnt4);
    end
    // Competitor arrives: the revocation must come exactly when the restarted count hits 4.
    for (int k = 0; k < 3; k++) tick(4'b1001, 1'b0, 1'b0);
    total++;
    if (obs_to[1] !== 1'b0 || gnt4 !== 4'b1000) begin
      bad++; $display("FAIL midreset_early: got to=%b gnt=%b want to=0 gnt=1000", obs_to[1], gnt4);
    end
    tick(4'b1001, 1'b0, 1'b0);
    total++;
    if (obs_to[1] !== 1'b1 || gnt4 !== 4'b0001) begin
      bad++; $display("FAIL midreset_count: got to=%b gnt=%b want to=1 gnt=0001", obs_to[1], gnt4);
    end
    // Build up a pending revocation again, then reset on that cycle: pulse must be cancelled.
    for (int k = 0; k < 3; k++) tick(4'b1001, 1'b0, 1'b0);
    tick(4'b1001, 1'b0, 1'b1);
    total++;
    if (obs_to[1] !== 1'b0 || obs[1] !== 8'h00) begin
      bad++; $display("FAIL midreset_cancel: got to=%b out=%b want 0", obs_to[1], obs[1]);
    end
    $display("reset mid-grant: out=%b", obs[1]);
  endtask

  task automatic test_random();
    logic [3:0] r;
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) r = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 3) == 0) r = r ^ (4'b1 << $urandom_range(0, 3));
      tick(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 59) == 0));
      for (int d = 0; d < 2; d++) begin
        total++;
        if (obs[d] !== exp_v[d]) begin
          bad++; $display("FAIL random dut%0d i%0d req=%b: got %b want %b", d, i, r, obs[d], exp_v[d]);
        end
      end
    end
    $display("random: 400 cycles compared");
  endtask

  initial begin
    reset = 1'b1; req = 4'b0000; prio_mode = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1; m_hold[d] = 0; m_ptr[d] = 3;
    end
    @(negedge clk);
    test_reset();
    test_basic();
    test_rr_fairness();
    test_timeout();
    test_lone_owner();
    test_fixed();
    test_reset_mid_grant();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
